// File: rtl/parity_mem_writer_pkg.sv
// Shared definitions for the two-bank parity memory (writer and checker sides).
package parity_mem_writer_pkg;

    localparam int DATA_W      = 8;
    localparam int BANK_DEPTH  = 8;
    localparam int TOTAL_DEPTH = 2 * BANK_DEPTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } fill_state_t;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_mem_writer_gen.sv
// Combinational parity generator: XOR-reduce of the byte, inverted for odd parity.
module parity_gen #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = (^data) ^ PARITY_ODD;

endmodule

// File: rtl/parity_mem_writer.sv
// Write side of the two-bank parity memory: handshaked byte writes with a
// per-entry parity bit, auto-incrementing pointer and a registered read port.
module parity_mem_writer
    import parity_mem_writer_pkg::*;
#(
    parameter int DATA_W     = parity_mem_writer_pkg::DATA_W,
    parameter int BANK_DEPTH = parity_mem_writer_pkg::BANK_DEPTH,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              err_inject,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_parity,
    output logic              rd_valid,
    output logic [3:0]        wr_ptr,
    output logic [4:0]        count,
    output logic              full
);

    localparam int AW = $clog2(BANK_DEPTH);
    // Contents of an entry after reset: zero data with its matching parity bit.
    localparam logic [DATA_W:0] RESET_WORD = {calc_parity('0, PARITY_ODD), {DATA_W{1'b0}}};

    fill_state_t       state_q, state_d;
    logic [4:0]        count_q, count_d;
    logic              wr_en;
    logic              wr_par;
    logic [DATA_W:0]   wr_word;

    logic [DATA_W:0]   bank0 [BANK_DEPTH];
    logic [DATA_W:0]   bank1 [BANK_DEPTH];

    logic [DATA_W:0]   rd_word_p1;
    logic              vld_p1;

    parity_gen #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity_gen (
        .data   (in_data),
        .parity (wr_par)
    );

    assign in_ready = (state_q != FULL);
    assign wr_ptr   = count_q[3:0];
    assign count    = count_q;
    assign full     = (state_q == FULL);
    // err_inject deliberately corrupts the stored parity so the checker can be exercised.
    assign wr_word  = {wr_par ^ err_inject, in_data};

    // Next-state logic: clear wins over a concurrent write, which is then dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (clear) begin
            state_d = EMPTY;
            count_d = 5'd0;
        end else if (in_valid && in_ready) begin
            wr_en   = 1'b1;
            count_d = count_q + 5'd1;
            state_d = (count_q == 5'(TOTAL_DEPTH - 1)) ? FULL : FILL;
        end
    end

    // Fill state and entry counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Bank storage: pointer bit AW selects the bank, lower bits the entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                bank0[i] <= RESET_WORD;
                bank1[i] <= RESET_WORD;
            end
        end else if (wr_en) begin
            if (wr_ptr[AW])
                bank1[wr_ptr[AW-1:0]] <= wr_word;
            else
                bank0[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    // ---- stage p1: registered read, sees pre-write contents on a same-cycle collision ----
    // Read register: data holds when no read is requested.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_word_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en)
                rd_word_p1 <= rd_addr[AW] ? bank1[rd_addr[AW-1:0]] : bank0[rd_addr[AW-1:0]];
        end
    end

    assign rd_data   = rd_word_p1[DATA_W-1:0];
    assign rd_parity = rd_word_p1[DATA_W];
    assign rd_valid  = vld_p1;

endmodule
